// File: rtl/uart_rx_word_fifo.sv
// Packs UART bytes MSB-first into 32-bit words and buffers them in a FWFT FIFO; a word shows on rd_data one edge after its 4th byte.
// No backpressure to the receiver: a word completed while full is dropped and flags overflow. RX_TIMEOUT_EN adds the stale-fragment timeout.
module uart_rx_word_fifo #(
  parameter int          DEPTH_LOG2     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  frag_err
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [1:0]            phase;
  logic [23:0]           pack;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  timeout;

  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        ovf_evt;
  logic [31:0] word;

  assign word     = {pack, in_byte};
  assign rd_valid = (cnt != '0);
  assign push_req = in_valid && (phase == 2'd3) && !flush;
  assign pop      = rd_en && rd_valid && !flush;
  assign push_ok  = push_req && ((cnt != CNT_FULL) || pop);
  assign ovf_evt  = push_req && (cnt == CNT_FULL) && !pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 32'd0;
  assign count    = cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase  <= 2'd0;
      pack   <= 24'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      phase  <= 2'd0;
      pack   <= 24'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (in_valid) begin
        case (phase)
          2'd0:    pack[23:16] <= in_byte;
          2'd1:    pack[15:8]  <= in_byte;
          2'd2:    pack[7:0]   <= in_byte;
          default: ;
        endcase
        phase <= phase + 2'd1;
      end else if (timeout) begin
        phase <= 2'd0;
        pack  <= 24'd0;
      end
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; rd_data is masked while empty instead.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= word;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
    else if (clr_err) overflow <= 1'b0;
  end

`ifdef RX_TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign timeout = (phase != 2'd0) && !in_valid && (idle_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idle_cnt <= 32'd0;
      frag_err <= 1'b0;
    end else begin
      if (flush || in_valid || timeout) idle_cnt <= 32'd0;
      else if (phase != 2'd0)           idle_cnt <= idle_cnt + 32'd1;
      if (timeout && !flush)            frag_err <= 1'b1;
      else if (clr_err)                 frag_err <= 1'b0;
    end
  end
`else
  assign timeout  = 1'b0;
  assign frag_err = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Directed bench for uart_rx_word_fifo with a word scoreboard queue.
module tb_uart_rx_word_fifo;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        rd_en;
  logic        flush;
  logic        clr_err;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic        overflow;
  logic        frag_err;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];

  always #5 CLK = ~CLK;

  uart_rx_word_fifo #(.DEPTH_LOG2(4), .TIMEOUT_CYCLES(32'd10)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_byte(in_byte), .in_valid(in_valid),
    .rd_en(rd_en), .flush(flush), .clr_err(clr_err), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .overflow(overflow), .frag_err(frag_err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
    in_byte  = 8'hxx;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1);
    send_byte(w[23:16], 0);
    send_byte(w[15:8], 2);
    send_byte(w[7:0], 0);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_dat"}, rd_data, e);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    while (sb.size() > 0) pop_check(tag);
    check({tag, "_empty_vld"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_empty_cnt"}, {27'd0, count}, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; in_byte = 8'h00; in_valid = 1'b0;
    rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    #12;
    check("rst_vld", {31'd0, rd_valid}, 32'd0);
    check("rst_dat", rd_data, 32'd0);
    check("rst_cnt", {27'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_frag", {31'd0, frag_err}, 32'd0);
    #11 RST_N = 1'b1;
    tick();

    // Pack order and one-edge latency
    send_byte(8'h12, 2);
    send_byte(8'h34, 3);
    send_byte(8'h56, 1);
    check("pack_pre_vld", {31'd0, rd_valid}, 32'd0);
    send_byte(8'h78, 0);
    sb.push_back(32'h12345678);
    check("pack_vld", {31'd0, rd_valid}, 32'd1);
    check("pack_cnt", {27'd0, count}, 32'd1);
    pop_check("pack_pop");
    check("pack_after_vld", {31'd0, rd_valid}, 32'd0);
    check("pack_after_dat", rd_data, 32'd0);
    check("pack_after_cnt", {27'd0, count}, 32'd0);
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    check("underflow_cnt", {27'd0, count}, 32'd0);
    check("underflow_vld", {31'd0, rd_valid}, 32'd0);

    // Fill to full, then one more word is dropped
    for (int n = 0; n < 16; n++) begin
      send_word({24'd0, n[7:0]});
      sb.push_back({24'd0, n[7:0]});
    end
    check("full_cnt", {27'd0, count}, 32'd16);
    check("full_ovf_pre", {31'd0, overflow}, 32'd0);
    send_word(32'h0000_0010);
    check("ovf_cnt", {27'd0, count}, 32'd16);
    check("ovf_set", {31'd0, overflow}, 32'd1);

    // clr_err racing another dropped push: set wins
    send_byte(8'hEE, 0);
    send_byte(8'hEE, 0);
    send_byte(8'hEE, 0);
    in_valid = 1'b1; in_byte = 8'hEE; clr_err = 1'b1;
    tick();
    in_valid = 1'b0; clr_err = 1'b0;
    check("race_ovf", {31'd0, overflow}, 32'd1);
    check("race_cnt", {27'd0, count}, 32'd16);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_ovf", {31'd0, overflow}, 32'd0);
    drain_all("drain1");

    // Push and pop in the same cycle while full
    for (int n = 0; n < 16; n++) begin
      send_word(32'h5000_0000 + n);
      sb.push_back(32'h5000_0000 + n);
    end
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 0);
    check("pp_head", rd_data, sb[0]);
    in_valid = 1'b1; in_byte = 8'hDD; rd_en = 1'b1;
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    void'(sb.pop_front());
    sb.push_back(32'hAABBCCDD);
    check("pp_cnt", {27'd0, count}, 32'd16);
    check("pp_ovf", {31'd0, overflow}, 32'd0);
    check("pp_newhead", rd_data, sb[0]);
    drain_all("drain2");

    // Flush with words stored and bytes pending
    send_word(32'h0A0B0C0D);
    send_word(32'h1A1B1C1D);
    send_byte(8'h99, 0);
    send_byte(8'h98, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    check("flush_cnt", {27'd0, count}, 32'd0);
    check("flush_vld", {31'd0, rd_valid}, 32'd0);
    check("flush_dat", rd_data, 32'd0);
    send_word(32'h01020304);
    sb.push_back(32'h01020304);
    check("flush_new_cnt", {27'd0, count}, 32'd1);
    pop_check("flush_pop");

    // Asynchronous reset mid-word
    send_word(32'h0A0B0C0D);
    send_word(32'h1A1B1C1D);
    send_byte(8'h99, 0);
    send_byte(8'h98, 0);
    #2 RST_N = 1'b0;
    #1;
    sb.delete();
    check("arst_cnt", {27'd0, count}, 32'd0);
    check("arst_vld", {31'd0, rd_valid}, 32'd0);
    check("arst_dat", rd_data, 32'd0);
    #3 RST_N = 1'b1;
    tick();
    send_word(32'h01020304);
    sb.push_back(32'h01020304);
    pop_check("arst_pop");

`ifdef RX_TIMEOUT_EN
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (9) tick();
    check("to_frag_early", {31'd0, frag_err}, 32'd0);
    tick();
    check("to_frag_set", {31'd0, frag_err}, 32'd1);
    send_word(32'hA0A1A2A3);
    sb.push_back(32'hA0A1A2A3);
    pop_check("to_pop");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_frag_clr", {31'd0, frag_err}, 32'd0);
    send_byte(8'h55, 9);
    send_byte(8'h66, 0);
    check("to_coincide", {31'd0, frag_err}, 32'd0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    sb.push_back(32'h55667788);
    pop_check("to_coincide_pop");
`else
    send_byte(8'h11, 0);
    send_byte(8'h22, 30);
    check("nto_frag", {31'd0, frag_err}, 32'd0);
    check("nto_vld", {31'd0, rd_valid}, 32'd0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    sb.push_back(32'h11223344);
    pop_check("nto_pop");
`endif

    check("final_sb", sb.size(), 32'd0);
    check("final_cnt", {27'd0, count}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_word_fifo.md
Name: uart_rx_word_fifo

Overview:
- Sits directly downstream of the UART byte receiver, in the same CLK domain.
- Takes each single-cycle (byte, valid) strobe from the receiver and packs every 4 bytes into a 32-bit word, first byte in the MSB.
- Buffers completed words in a first-word-fall-through (FWFT) FIFO that the CPU/loader drains with a read-enable.
- Flags overflow, and optionally stale partial words, so the host link can detect lost data.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in words (default depth 16).
- TIMEOUT_CYCLES, 32'd2000000, idle CLK cycles before a partial word is discarded (used only with RX_TIMEOUT_EN).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- in_byte  input  8  received byte from the UART receiver.
- in_valid  input  1  one-cycle strobe: in_byte is valid this cycle.
- rd_en  input  1  pop request from the consumer.
- flush  input  1  synchronous clear of the FIFO and the packer.
- clr_err  input  1  synchronous clear of the sticky error flags.
- rd_data  output  32  head word of the FIFO, valid when rd_valid=1.
- rd_valid  output  1  FIFO non-empty.
- count  output  DEPTH_LOG2+1  number of words stored (0..2^DEPTH_LOG2).
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
- frag_err  output  1  sticky: a partial word was discarded (RX_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
Reset
- Asynchronous on RST_N=0.
- Cleared: byte phase, pack register, read/write pointers, count, overflow, frag_err, timeout counter.
- rd_valid=0.
- rd_data=0 (the storage array is not required to be reset; rd_data is masked to 0 while empty).
- Reset mid-word discards the partial bytes.

Packer
- Holds a 2-bit phase p and a 24-bit shift register.
- in_valid with p<3: store the byte, p<=p+1.
  - p=0 -> bits [31:24]; p=1 -> [23:16]; p=2 -> [15:8].
- in_valid with p=3: form the word {b0,b1,b2,in_byte}, issue a push this cycle, p<=0.
- in_byte is ignored whenever in_valid=0.

FIFO
- Depth 2^DEPTH_LOG2.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth; count is tracked explicitly.
- Push accepted iff count<depth, or a pop occurs in the same cycle.
- Push while full with no pop:
  - word dropped, overflow<=1;
  - count, pointers and stored data unchanged;
  - packer still returns to p=0.
- Pop occurs iff rd_en=1 and rd_valid=1. rd_en while empty is ignored, with no underflow and no state change.
- Simultaneous push and pop: both performed, count unchanged. This holds at full and at count=1.
- FWFT timing: a word pushed at edge t is visible on rd_data with rd_valid=1 immediately after edge t (one-cycle latency from the 4th in_valid).
- After a pop at edge t, rd_data shows the next word (or 0 if now empty) after edge t.
- Push into an empty FIFO while rd_en=1: no pop that cycle, because rd_valid was 0.

Control priority, highest first
1. flush: pointers and count <=0, p<=0, pack register and timeout counter cleared. Any push or pop in the same cycle is discarded. Sticky flags are unaffected.
2. clr_err: overflow and frag_err <=0. If an overflow event occurs in the same cycle, overflow<=1 (the set wins).
3. Normal push/pop.

Optional Feature:
Macro RX_TIMEOUT_EN.
- Defined:
  - 32-bit idle counter, cleared on every in_valid, on flush and on reset.
  - It increments only while p!=0.
  - When it reaches TIMEOUT_CYCLES-1 with p!=0 and no in_valid that cycle: p<=0, partial bytes discarded, frag_err<=1, counter<=0.
  - If in_valid coincides with the expiry cycle, the byte is accepted and no timeout occurs.
- Undefined:
  - No counter is built; frag_err is tied to 0.
  - A partial word waits indefinitely for its remaining bytes.

Test Plan:
- Pack/order: after reset, push bytes 0x12,0x34,0x56,0x78 with gaps -> rd_valid rises one edge after the 0x78 strobe; rd_data=0x12345678; count=1. rd_en one cycle -> rd_valid=0, rd_data=0, count=0.
- Fill/overflow (DEPTH_LOG2=4): push 17 words N=0..16 (bytes 0,0,0,N) -> count=16, overflow=1. Drain 16 pops -> words 0..15 in order, word 16 absent.
- Push+pop at full: fill 16 words; deliver the 4th byte of word 0xAABBCCDD in the same cycle as rd_en -> count stays 16, overflow=0, 0xAABBCCDD is the last word drained.
- Flush/reset mid-operation: 2 words stored plus 2 bytes pending.
  - Assert flush -> count=0, rd_valid=0.
  - Then push 4 bytes 0x01..0x04 -> rd_data=0x01020304.
  - Repeat with RST_N pulsed low asynchronously -> same result.
- clr_err/overflow race: overflow=1; assert clr_err in the same cycle as another dropped push -> overflow remains 1. Next clr_err alone -> 0.
- RX_TIMEOUT_EN, TIMEOUT_CYCLES=10: push 0x11,0x22 then idle -> frag_err=1 after 10 idle cycles, phase reset. Then push 0xA0,0xA1,0xA2,0xA3 -> rd_data=0xA0A1A2A3.
